// File: rtl/machine_cycle_sequencer_if.sv
// Control/status bundle between the sequencer and the processor core.
// The master side drives run controls; the slave side returns the phase code.
interface machine_cycle_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 step_mode;
    logic                 step_req;
    logic                 halt_req;
    logic [2:0]           count_state;
    logic                 flag;
    logic [CNT_WIDTH-1:0] instr_count;
    logic                 halted;

    modport master (
        output enable,
        output step_mode,
        output step_req,
        output halt_req,
        input  count_state,
        input  flag,
        input  instr_count,
        input  halted
    );

    modport slave (
        input  enable,
        input  step_mode,
        input  step_req,
        input  halt_req,
        output count_state,
        output flag,
        output instr_count,
        output halted
    );
endinterface

// File: rtl/machine_cycle_sequencer.sv
// Machine-cycle phase sequencer: steps FETCH..LAST per instruction,
// with free-run, single-step and boundary halt, plus a retired counter.
module machine_cycle_sequencer #(
    parameter int MAXIMUM_VALUE = 6,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    machine_cycle_sequencer_if.slave  bus
);
    localparam logic [2:0] LAST = 3'(MAXIMUM_VALUE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [2:0]           phase;
    logic [2:0]           phase_nx;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nx;
    logic                 start;

    // A parked sequencer launches only when no halt is pending.
    assign start = !bus.halt_req && (!bus.step_mode || bus.step_req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            phase <= 3'd0;
            count <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        count_nx = count;
        if (bus.enable) begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state_nx = RUN;
                        phase_nx = 3'd1;
                    end
                end
                RUN: begin
                    if (phase == LAST) begin
                        count_nx = count + 1'b1;
                        // Halt and step only take effect on an instruction boundary.
                        if (bus.halt_req || bus.step_mode) begin
                            state_nx = HALT;
                            phase_nx = 3'd0;
                        end else begin
                            phase_nx = 3'd1;
                        end
                    end else begin
                        phase_nx = phase + 3'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    phase_nx = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        bus.count_state = phase;
        bus.flag        = (state == RUN) && (phase == LAST);
        bus.instr_count = count;
        bus.halted      = (state == HALT);
    end
endmodule

// File: tb/tb_machine_cycle_sequencer.sv
// Directed bench for machine_cycle_sequencer (MAXIMUM_VALUE=6, CNT_WIDTH=4).
// Each task drives one scenario and checks hand-computed expectations.
module tb_machine_cycle_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    machine_cycle_sequencer_if #(.CNT_WIDTH(4)) bus ();

    machine_cycle_sequencer #(
        .MAXIMUM_VALUE(6),
        .CNT_WIDTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.enable    = 1'b0;
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
        bus.halt_req  = 1'b0;
        #2;
        n_checks++;
        if (bus.count_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cs: got %0d expected 0", bus.count_state);
        end
        n_checks++;
        if (bus.flag !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got flag=%b halted=%b expected 0 0",
                     bus.flag, bus.halted);
        end
        n_checks++;
        if (bus.instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.instr_count);
        end
        tick();
        tick();
    endtask

    task automatic test_free_run();
        int exp_cs;
        bus.enable    = 1'b1;
        bus.step_mode = 1'b0;
        bus.halt_req  = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            exp_cs = (i % 5) + 1;
            n_checks++;
            if (bus.count_state !== 3'(exp_cs)
                || bus.flag !== (exp_cs == 5)) begin
                n_fail++;
                $display("FAIL free_run[%0d]: got cs=%0d flag=%b expected cs=%0d flag=%b",
                         i, bus.count_state, bus.flag, exp_cs, exp_cs == 5);
            end
        end
        n_checks++;
        if (bus.instr_count !== 4'd2) begin
            n_fail++;
            $display("FAIL free_run_cnt: got %0d expected 2", bus.instr_count);
        end
    endtask

    task automatic test_halt();
        int seq [6] = '{2, 3, 4, 5, 0, 0};
        int hlt [6] = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) bus.halt_req = 1'b1;
            n_checks++;
            if (bus.count_state !== 3'(seq[i]) || bus.halted !== hlt[i][0]) begin
                n_fail++;
                $display("FAIL halt[%0d]: got cs=%0d halted=%b expected cs=%0d halted=%0d",
                         i, bus.count_state, bus.halted, seq[i], hlt[i]);
            end
        end
        n_checks++;
        if (bus.instr_count !== 4'd3) begin
            n_fail++;
            $display("FAIL halt_cnt: got %0d expected 3", bus.instr_count);
        end
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        n_checks++;
        if (bus.count_state !== 3'd0 || bus.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_step_clash: got cs=%0d halted=%b expected cs=0 halted=1",
                     bus.count_state, bus.halted);
        end
        bus.halt_req = 1'b0;
        tick();
        n_checks++;
        if (bus.count_state !== 3'd1 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_resume: got cs=%0d halted=%b expected cs=1 halted=0",
                     bus.count_state, bus.halted);
        end
    endtask

    task automatic test_step();
        int req [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        int seq [13] = '{2, 3, 4, 5, 0, 0, 1, 2, 3, 4, 5, 0, 0};
        int cnt [13] = '{3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 4, 5, 5};
        bus.step_mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bus.step_req = req[i][0];
            tick();
            n_checks++;
            if (bus.count_state !== 3'(seq[i])
                || bus.instr_count !== 4'(cnt[i])
                || bus.halted !== (seq[i] == 0)) begin
                n_fail++;
                $display("FAIL step[%0d]: got cs=%0d cnt=%0d halted=%b expected cs=%0d cnt=%0d",
                         i, bus.count_state, bus.instr_count, bus.halted, seq[i], cnt[i]);
            end
        end
        bus.step_req = 1'b0;
    endtask

    task automatic test_freeze();
        bus.step_mode = 1'b0;
        tick();
        tick();
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.step_req = (i == 1);
            tick();
            n_checks++;
            if (bus.count_state !== 3'd3 || bus.flag !== 1'b0
                || bus.instr_count !== 4'd5) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got cs=%0d flag=%b cnt=%0d expected cs=3 flag=0 cnt=5",
                         i, bus.count_state, bus.flag, bus.instr_count);
            end
        end
        bus.step_req = 1'b0;
        bus.enable   = 1'b1;
        tick();
        n_checks++;
        if (bus.count_state !== 3'd4) begin
            n_fail++;
            $display("FAIL freeze_release: got %0d expected 4", bus.count_state);
        end
        tick();
        tick();
        n_checks++;
        if (bus.count_state !== 3'd1 || bus.instr_count !== 4'd6) begin
            n_fail++;
            $display("FAIL freeze_next: got cs=%0d cnt=%0d expected cs=1 cnt=6",
                     bus.count_state, bus.instr_count);
        end
    endtask

    task automatic test_reset_mid();
        int req [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        int hr  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int en  [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
        int seq [10] = '{0, 0, 0, 1, 0, 1, 2, 3, 4, 5};
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (bus.count_state !== 3'd4 || bus.instr_count !== 4'd7) begin
            n_fail++;
            $display("FAIL pre_reset: got cs=%0d cnt=%0d expected cs=4 cnt=7",
                     bus.count_state, bus.instr_count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.count_state !== 3'd0 || bus.flag !== 1'b0
            || bus.instr_count !== 4'd0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cs=%0d flag=%b cnt=%0d halted=%b expected all 0",
                     bus.count_state, bus.flag, bus.instr_count, bus.halted);
        end
        bus.step_mode = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.enable   = en[i][0];
            bus.step_req = req[i][0];
            bus.halt_req = hr[i][0];
            if (i == 4) bus.step_req = 1'b1;
            tick();
            if (i == 3) begin
                n_checks++;
                if (bus.count_state !== 3'd1) begin
                    n_fail++;
                    $display("FAIL idle_step: got %0d expected 1", bus.count_state);
                end
            end
        end
        tick();
        n_checks++;
        if (bus.count_state !== 3'd0 || bus.halted !== 1'b1
            || bus.instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL step_after_reset: got cs=%0d halted=%b cnt=%0d expected cs=0 halted=1 cnt=1",
                     bus.count_state, bus.halted, bus.instr_count);
        end
        bus.step_req = 1'b0;
        bus.halt_req = 1'b1;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        n_checks++;
        if (bus.count_state !== 3'd0 || bus.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_wins: got cs=%0d halted=%b expected cs=0 halted=1",
                     bus.count_state, bus.halted);
        end
        bus.halt_req = 1'b0;
    endtask

    task automatic test_wrap();
        int exp_cs;
        int exp_cnt;
        reset = 1'b0;
        #1;
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
        bus.halt_req  = 1'b0;
        bus.enable    = 1'b1;
        reset = 1'b1;
        for (int k = 1; k <= 81; k++) begin
            tick();
            exp_cs  = ((k - 1) % 5) + 1;
            exp_cnt = ((k - 1) / 5) % 16;
            n_checks++;
            if (bus.count_state !== 3'(exp_cs) || bus.instr_count !== 4'(exp_cnt)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got cs=%0d cnt=%0d expected cs=%0d cnt=%0d",
                         k, bus.count_state, bus.instr_count, exp_cs, exp_cnt);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_free_run();
        test_halt();
        test_step();
        test_freeze();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
